// File: rtl/cdec8_ctrl_unit_if.sv
// Control-unit <-> datapath bundle: instruction and flags in, control word,
// debug state code and halt indication out.
interface cdec8_ctrl_unit_if;
   logic [7:0]  I;
   logic [2:0]  SZCy;
   logic [16:0] ctrl;
   logic [7:0]  state;
   logic        halt;

   modport master (input I, SZCy, output ctrl, state, halt);
   modport slave  (output I, SZCy, input ctrl, state, halt);
endinterface

// File: rtl/cdec8_ctrl_unit.sv
// CDEC8 control FSM: fetch / operand fetch / execute sequencing that decodes
// the 17-bit datapath control word from state, I and SZCy.
// Optional feature macro: CDEC8_SINGLE_STEP_EN (adds step_mode/step and WAIT).
module cdec8_ctrl_unit #(
   parameter bit ILLEGAL_HALT = 1'b0
) (
   input  logic clock,
   input  logic reset_N,
`ifdef CDEC8_SINGLE_STEP_EN
   input  logic step_mode,
   input  logic step,
`endif
   cdec8_ctrl_unit_if.master bus
);
   localparam int unsigned SW = 4;
   localparam int unsigned CW = 17;

   localparam logic [SW-1:0] S_RST  = 4'h0;
   localparam logic [SW-1:0] S_F0   = 4'h1;
   localparam logic [SW-1:0] S_F1   = 4'h2;
   localparam logic [SW-1:0] S_F2   = 4'h3;
   localparam logic [SW-1:0] S_DEC  = 4'h4;
   localparam logic [SW-1:0] S_O0   = 4'h5;
   localparam logic [SW-1:0] S_O1   = 4'h6;
   localparam logic [SW-1:0] S_X0   = 4'h7;
   localparam logic [SW-1:0] S_X1   = 4'h8;
   localparam logic [SW-1:0] S_X2   = 4'h9;
   localparam logic [SW-1:0] S_WAIT = 4'hE;
   localparam logic [SW-1:0] S_HALT = 4'hF;

   // register-file select codes (src and dst share numbering)
   localparam logic [3:0] R_PC  = 4'h0;
   localparam logic [3:0] R_A   = 4'h1;
   localparam logic [3:0] R_B   = 4'h2;
   localparam logic [3:0] R_C   = 4'h3;
   localparam logic [3:0] R_R   = 4'h4;   // src: ALU result
   localparam logic [3:0] R_MAR = 4'h4;   // dst
   localparam logic [3:0] R_RDR = 4'h5;   // src
   localparam logic [3:0] R_WDR = 4'h5;   // dst
   localparam logic [3:0] R_T   = 4'h6;
   localparam logic [3:0] R_I   = 4'h7;
   localparam logic [3:0] R_IO  = 4'h8;   // IPORT src / OPORT dst
   localparam logic [3:0] R_NONE = 4'hF;

   localparam logic [4:0] OP_INC = 5'h01;
   localparam logic [4:0] OP_ADD = 5'h04;
   localparam logic [4:0] OP_SUB = 5'h05;
   localparam logic [4:0] OP_AND = 5'h08;
   localparam logic [4:0] OP_OR  = 5'h09;

   localparam logic [1:0] MM_RD = 2'b10;
   localparam logic [1:0] MM_WR = 2'b01;

   logic [SW-1:0] st_q, st_d;
   logic [3:0]    opc;
   logic [1:0]    rsel;
   logic [3:0]    r_code;
   logic [4:0]    alu_op;
   logic          illegal;
   logic          cond_sel, cond_true;
   logic [SW-1:0] start_st;

   logic [1:0] mm;
   logic       fw, rw;
   logic [3:0] dst, src;
   logic [4:0] op;
   logic [CW-1:0] ctrl_w;

   // instruction field decode shared by next-state and output logic
   always_comb begin
      opc    = bus.I[7:4];
      rsel   = bus.I[1:0];
      r_code = R_NONE;
      alu_op = OP_ADD;
      case (rsel)
         2'd0:    r_code = R_A;
         2'd1:    r_code = R_B;
         2'd2:    r_code = R_C;
         default: r_code = R_NONE;
      endcase
      case (opc[1:0])
         2'd0:    alu_op = OP_ADD;
         2'd1:    alu_op = OP_SUB;
         2'd2:    alu_op = OP_AND;
         default: alu_op = OP_OR;
      endcase
      case (rsel)
         2'd0:    cond_sel = bus.SZCy[1];
         2'd1:    cond_sel = bus.SZCy[0];
         2'd2:    cond_sel = bus.SZCy[2];
         default: cond_sel = 1'b1;
      endcase
      cond_true = cond_sel ^ bus.I[2];
      // reserved register field only matters for opcodes that name a register
      illegal = (opc inside {4'hC, 4'hD, 4'hE}) ||
                ((opc inside {[4'h1:4'h7]}) && (rsel == 2'd3));
   end

   // fetch entry point: F0, or WAIT when single-stepping without a pulse
   always_comb begin
`ifdef CDEC8_SINGLE_STEP_EN
      start_st = (step_mode && !step) ? S_WAIT : S_F0;
`else
      start_st = S_F0;
`endif
   end

   // state register
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) st_q <= S_RST;
      else          st_q <= st_d;
   end

   // next-state selection
   always_comb begin
      st_d = st_q;
      case (st_q)
         S_RST:  st_d = start_st;
         S_F0:   st_d = S_F1;
         S_F1:   st_d = S_F2;
         S_F2:   st_d = S_DEC;
         S_DEC: begin
            if (illegal)                              st_d = ILLEGAL_HALT ? S_HALT : start_st;
            else if (opc inside {4'h1, 4'h2, 4'h3, 4'h8, 4'h9}) st_d = S_O0;
            else if (opc inside {[4'h4:4'h7], 4'hA, 4'hB})      st_d = S_X0;
            else if (opc == 4'hF)                     st_d = S_HALT;
            else                                      st_d = start_st;
         end
         S_O0:   st_d = S_O1;
         S_O1:   st_d = S_X0;
         S_X0:   st_d = (opc inside {[4'h2:4'h7]}) ? S_X1 : start_st;
         S_X1:   st_d = S_X2;
         S_X2:   st_d = start_st;
         S_WAIT: st_d = start_st;
         S_HALT: st_d = S_HALT;
         default: st_d = S_RST;
      endcase
   end

   // control word decode; every field defaults to the idle word
   always_comb begin
      mm  = 2'b00;
      fw  = 1'b0;
      rw  = 1'b0;
      dst = R_NONE;
      op  = 5'h00;
      src = R_NONE;
      case (st_q)
         S_F0, S_O0: begin dst = R_MAR; src = R_PC; op = OP_INC; rw = 1'b1; end
         S_F1, S_O1: begin mm = MM_RD; dst = R_PC; src = R_R; end
         S_F2:       begin dst = R_I; src = R_RDR; end
         S_X0: begin
            case (opc)
               4'h1:             begin dst = r_code; src = R_RDR; end
               4'h2, 4'h3:       begin dst = R_MAR;  src = R_RDR; end
               4'h4, 4'h5, 4'h6, 4'h7: begin dst = R_T; src = r_code; end
               4'h8:             begin dst = R_PC;   src = R_RDR; end
               4'h9:             if (cond_true) begin dst = R_PC; src = R_RDR; end
               4'hA:             begin dst = R_A;    src = R_IO; end
               4'hB:             begin dst = R_IO;   src = R_A; end
               default: ;
            endcase
         end
         S_X1: begin
            case (opc)
               4'h2:             mm = MM_RD;
               4'h3:             begin dst = R_WDR; src = r_code; end
               4'h4, 4'h5, 4'h6, 4'h7: begin src = R_A; op = alu_op; rw = 1'b1; fw = 1'b1; end
               default: ;
            endcase
         end
         S_X2: begin
            case (opc)
               4'h2:             begin dst = r_code; src = R_RDR; end
               4'h3:             mm = MM_WR;
               4'h4, 4'h5, 4'h6, 4'h7: begin dst = R_A; src = R_R; end
               default: ;
            endcase
         end
         default: ;
      endcase
      ctrl_w = {mm, fw, rw, dst, op, src};
   end

   assign bus.ctrl  = ctrl_w;
   assign bus.state = 8'(st_q);
   assign bus.halt  = (st_q == S_HALT);
endmodule
